// File: rtl/apb_slave_mux_pkg.sv
// Shared definitions for the AHB-to-APB bridge: FSM encodings, default
// slave-map geometry and the bus width macros.
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_slave_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_NUM_SLAVES   = 4;
  localparam int DEF_SLV_IDX_W    = 3;
  localparam int DEF_SLV_ADDR_LSB = 12;
  localparam int DEF_TIMEOUT_CYC  = 16;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational APB address decode: slave index field, mapped flag and
// one-hot slave selects gated by an enable.
module apb_addr_decode
  import apb_slave_mux_pkg::*;
#(
  parameter int NUM_SLAVES   = DEF_NUM_SLAVES,
  parameter int SLV_IDX_W    = DEF_SLV_IDX_W,
  parameter int SLV_ADDR_LSB = DEF_SLV_ADDR_LSB,
  parameter int PADDR_W      = `PADDR_WIDTH
) (
  input  logic [PADDR_W-1:0]    paddr,
  input  logic                  en,
  output logic [SLV_IDX_W-1:0]  idx,
  output logic                  mapped,
  output logic [NUM_SLAVES-1:0] sel
);

  // Only the index field matters here; the rest of the address is the slave offset.
  logic paddr_unused;
  assign paddr_unused = ^paddr;

  assign idx    = paddr[SLV_ADDR_LSB +: SLV_IDX_W];
  assign mapped = (32'(idx) < 32'(NUM_SLAVES));

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = en && (idx == SLV_IDX_W'(i));
    end
  end

endmodule

// File: rtl/apb_slave_mux.sv
// APB fan-out/fan-in stage of the AHB-to-APB bridge: slave select decode,
// response mux, read-data capture and unmapped/timeout error termination.
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module apb_slave_mux
  import apb_slave_mux_pkg::*;
#(
  parameter int NUM_SLAVES   = DEF_NUM_SLAVES,
  parameter int SLV_IDX_W    = DEF_SLV_IDX_W,
  parameter int SLV_ADDR_LSB = DEF_SLV_ADDR_LSB,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter int PADDR_W      = `PADDR_WIDTH,
  parameter int PDATA_W      = `APB_DATA_WIDTH
) (
  input  logic                          hclk,
  input  logic                          hreset_n,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [PADDR_W-1:0]            paddr,
  output logic [NUM_SLAVES-1:0]         psel_s,
  input  logic [NUM_SLAVES-1:0]         pready_s,
  input  logic [NUM_SLAVES-1:0]         pslverr_s,
  input  logic [NUM_SLAVES*PDATA_W-1:0] prdata_s,
  output logic                          pready_x,
  output logic                          pslverr_x,
  output logic [PDATA_W-1:0]            hrdata
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  apb_state_e           state;
  logic [SLV_IDX_W-1:0] sel_idx_q;
  logic                 unmapped_q;
  logic [CNT_W-1:0]     cnt;

  logic [SLV_IDX_W-1:0] idx;
  logic                 mapped;
  logic                 dec_en;
  logic                 slv_rdy;
  logic                 slv_err;
  logic [PDATA_W-1:0]   slv_rdata;
  logic                 timeout;
  logic                 done;
  logic                 rsp_err;
  logic                 new_xfer;

  // Selects stay quiet while reset is held, even if the bridge still drives psel.
  assign dec_en = psel && hreset_n;

  apb_addr_decode #(
    .NUM_SLAVES  (NUM_SLAVES),
    .SLV_IDX_W   (SLV_IDX_W),
    .SLV_ADDR_LSB(SLV_ADDR_LSB),
    .PADDR_W     (PADDR_W)
  ) u_addr_decode (
    .paddr (paddr),
    .en    (dec_en),
    .idx   (idx),
    .mapped(mapped),
    .sel   (psel_s)
  );

  always_comb begin
    slv_rdy   = 1'b0;
    slv_err   = 1'b0;
    slv_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!unmapped_q && (sel_idx_q == SLV_IDX_W'(i))) begin
        slv_rdy   = pready_s[i];
        slv_err   = pslverr_s[i];
        slv_rdata = prdata_s[i*PDATA_W +: PDATA_W];
      end
    end
  end

  // A slave answering on the timeout cycle wins over the forced error.
  assign timeout   = (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign done      = (state == ST_ACCESS) && (unmapped_q || slv_rdy || timeout);
  assign rsp_err   = unmapped_q || slv_err || (timeout && !slv_rdy);
  assign pready_x  = done;
  assign pslverr_x = done && rsp_err;
  assign new_xfer  = psel && !penable;

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state      <= ST_IDLE;
      sel_idx_q  <= '0;
      unmapped_q <= 1'b0;
      cnt        <= '0;
      hrdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (new_xfer) begin
            state      <= ST_SETUP;
            sel_idx_q  <= idx;
            unmapped_q <= !mapped;
            cnt        <= '0;
          end
        end
        ST_SETUP: begin
          state <= psel ? ST_ACCESS : ST_IDLE;
        end
        ST_ACCESS: begin
          if (done) begin
            if (!pwrite) begin
              hrdata <= rsp_err ? '0 : slv_rdata;
            end
            if (new_xfer) begin
              state      <= ST_SETUP;
              sel_idx_q  <= idx;
              unmapped_q <= !mapped;
              cnt        <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_mux.sv
// Randomized bench for apb_slave_mux with a transaction-level reference model.
module tb_apb_slave_mux;

  localparam int NS  = 4;
  localparam int IW  = 3;
  localparam int LSB = 12;
  localparam int TO  = 16;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 2;

  logic                  hclk = 1'b0;
  logic                  hreset_n;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [AW-1:0]         paddr;
  logic [NS-1:0]         psel_s;
  logic [NS-1:0]         pready_s;
  logic [NS-1:0]         pslverr_s;
  logic [NS-1:0][DW-1:0] prd;
  logic [NS*DW-1:0]      prdata_s;
  logic                  pready_x;
  logic                  pslverr_x;
  logic [DW-1:0]         hrdata;

  logic [DW-1:0]         hrdata_exp;
  int                    n_chk  = 0;
  int                    n_pass = 0;

  assign prdata_s = prd;

  always #5 hclk = ~hclk;

  apb_slave_mux #(
    .NUM_SLAVES  (NS),
    .SLV_IDX_W   (IW),
    .SLV_ADDR_LSB(LSB),
    .TIMEOUT_CYC (TO),
    .PADDR_W     (AW),
    .PDATA_W     (DW)
  ) dut (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .psel_s   (psel_s),
    .pready_s (pready_s),
    .pslverr_s(pslverr_s),
    .prdata_s (prdata_s),
    .pready_x (pready_x),
    .pslverr_x(pslverr_x),
    .hrdata   (hrdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  function automatic logic [NS-1:0] exp_sel(input logic [AW-1:0] a);
    int i;
    i = int'(a[LSB +: IW]);
    return (i < NS) ? (NS'(1) << i) : '0;
  endfunction

  task automatic noise();
    pready_s  = NS'($urandom);
    pslverr_s = NS'($urandom);
    for (int i = 0; i < NS; i++) prd[i] = $urandom;
  endtask

  // One bridge transfer. d = ACCESS cycle on which the slave answers (0 or >TO: never).
  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input int d, input logic err,
                      input logic [DW-1:0] data, input bit in_setup, input bit b2b,
                      input logic [AW-1:0] nxt);
    int idx, k;
    bit mapped, rdy_hit, eerr;
    idx     = int'(addr[LSB +: IW]);
    mapped  = (idx < NS);
    rdy_hit = mapped && (d >= 1) && (d <= TO);
    k       = !mapped ? 1 : (rdy_hit ? d : TO);
    eerr    = !mapped || err || !rdy_hit;
    if (!in_setup) begin
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; noise();
      @(negedge hclk);
      check("sel_first", 32'(psel_s), 32'(exp_sel(addr)));
      check("rdy_first", 32'(pready_x), 0);
      tick();
    end
    psel = 1'b1; penable = 1'b1; pwrite = wr; paddr = addr; noise();
    @(negedge hclk);
    check("sel_setup", 32'(psel_s), 32'(exp_sel(addr)));
    check("rdy_setup", 32'(pready_x), 0);
    check("hrdata_hold", hrdata, hrdata_exp);
    tick();
    for (int c = 1; c <= k; c++) begin
      noise();
      if (mapped) begin
        pready_s[SW'(idx)]  = (c == d);
        pslverr_s[SW'(idx)] = err;
        prd[SW'(idx)]       = data;
      end
      if (c == k && b2b) begin
        penable = 1'b0;
        paddr   = nxt;
      end
      @(negedge hclk);
      check("sel_access", 32'(psel_s), 32'(exp_sel(paddr)));
      check("pready_x", 32'(pready_x), 32'(c == k));
      check("pslverr_x", 32'(pslverr_x), 32'((c == k) && eerr));
      tick();
    end
    if (!wr) hrdata_exp = eerr ? '0 : data;
    if (!b2b) begin
      psel = 1'b0; penable = 1'b0; noise();
      @(negedge hclk);
      check("hrdata", hrdata, hrdata_exp);
      check("rdy_after", 32'(pready_x), 0);
      check("sel_after", 32'(psel_s), 0);
      tick();
    end
  endtask

  logic [AW-1:0] c_addr, n_addr;
  logic          c_wr, n_wr, c_err, n_err;
  int            c_d, n_d;
  logic [DW-1:0] c_data, n_data;
  bit            prev_b2b, b2b;

  initial begin
    hreset_n = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h2000;
    noise();
    hrdata_exp = '0;
    tick(); tick();
    check("rst_psel_s", 32'(psel_s), 0);
    check("rst_pready", 32'(pready_x), 0);
    check("rst_pslverr", 32'(pslverr_x), 0);
    check("rst_hrdata", hrdata, 0);
    psel = 1'b0;
    hreset_n = 1'b1;
    tick();

    // Directed cases
    xfer(32'h2004, 1'b0, 3, 1'b0, 32'hDEADBEEF, 0, 0, '0);
    xfer(32'h0010, 1'b1, 1, 1'b1, 32'h12345678, 0, 0, '0);
    xfer(32'h5000, 1'b0, 1, 1'b0, 32'hCAFEF00D, 0, 0, '0);
    xfer(32'h3000, 1'b0, 2, 1'b0, 32'hA5A5A5A5, 0, 0, '0);
    xfer(32'h1000, 1'b0, 0, 1'b0, 32'h11111111, 0, 0, '0);
    pready_s = '1; pslverr_s = '1;
    @(negedge hclk);
    check("late_rdy", 32'(pready_x), 0);
    tick();
    xfer(32'h2000, 1'b0, TO, 1'b0, 32'h0BADF00D, 0, 0, '0);
    xfer(32'h3008, 1'b0, 10, 1'b0, 32'h33333333, 0, 1, 32'h1000);
    xfer(32'h1000, 1'b0, 0, 1'b0, 32'h44444444, 1, 0, '0);

    // penable without a setup phase must be ignored
    psel = 1'b1; penable = 1'b1; paddr = 32'h0000; pready_s = '1; pslverr_s = '1;
    for (int i = 0; i < 2; i++) begin
      @(negedge hclk);
      check("viol_rdy", 32'(pready_x), 0);
      check("viol_err", 32'(pslverr_x), 0);
      tick();
    end
    psel = 1'b0; penable = 1'b0;
    tick();
    xfer(32'h2040, 1'b0, 1, 1'b0, 32'h55AA55AA, 0, 0, '0);

    // Reset during ACCESS cycle 2 of a slave-2 read
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h2000; noise(); pready_s[2] = 1'b0;
    tick();
    penable = 1'b1; pready_s[2] = 1'b0;
    tick();
    pready_s[2] = 1'b0;
    tick();
    pready_s[2] = 1'b1; pslverr_s[2] = 1'b0;
    hreset_n = 1'b0;
    #1;
    check("midrst_sel", 32'(psel_s), 0);
    check("midrst_rdy", 32'(pready_x), 0);
    check("midrst_err", 32'(pslverr_x), 0);
    check("midrst_hrdata", hrdata, 0);
    hrdata_exp = '0;
    psel = 1'b0; penable = 1'b0;
    tick();
    hreset_n = 1'b1;
    tick();
    xfer(32'h0004, 1'b0, 2, 1'b0, 32'h600DCAFE, 0, 0, '0);

    // Randomized transfers, some chained back-to-back
    c_addr = $urandom; c_wr = 1'($urandom); c_d = $urandom_range(0, TO + 1);
    c_err = 1'($urandom); c_data = $urandom;
    prev_b2b = 0;
    for (int i = 0; i < 40; i++) begin
      n_addr = $urandom; n_wr = 1'($urandom); n_d = $urandom_range(0, TO + 1);
      n_err = 1'($urandom); n_data = $urandom;
      b2b = (i < 39) && ($urandom_range(0, 2) == 0);
      xfer(c_addr, c_wr, c_d, c_err, c_data, prev_b2b, b2b, n_addr);
      prev_b2b = b2b;
      c_addr = n_addr; c_wr = n_wr; c_d = n_d; c_err = n_err; c_data = n_data;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
